// File: rtl/mips_store_pkg.sv
// Shared types and constants for the MIPS store unit.
//   store_op_t : store opcode encoding on req_op (5-7 reserved)
//   state_t    : store unit FSM states
//   BE_*       : base byte-enable lane masks, shifted by the byte offset
package mips_store_pkg;

    typedef enum logic [2:0] {
        OP_SB  = 3'd0,
        OP_SH  = 3'd1,
        OP_SW  = 3'd2,
        OP_SWL = 3'd3,
        OP_SWR = 3'd4
    } store_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_store_lane.sv
// Combinational lane steering for stores (little-endian).
//   op         : store opcode (store_op_t encoding, 5-7 reserved)
//   b          : byte offset addr[1:0]
//   data       : rt register value
//   byteenable : active byte lanes, bit i = byte i
//   writedata  : lane-aligned data, unused lanes zero
//   misaligned : misaligned SH/SW or reserved opcode
module mips_store_lane
    import mips_store_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  b,
    input  logic [31:0] data,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        misaligned
);

    logic [4:0] sh_up;
    logic [4:0] sh_swl;

    assign sh_up  = {b, 3'b000};
    // SWL places the high-order bytes of rt into lanes 0..b.
    assign sh_swl = 5'(5'd24 - {b, 3'b000});

    // Lane decode; error cases drive no lanes.
    always_comb begin
        byteenable = 4'b0000;
        writedata  = 32'd0;
        misaligned = 1'b0;
        case (op)
            OP_SB: begin
                byteenable = 4'(BE_BYTE << b);
                writedata  = {24'd0, data[7:0]} << sh_up;
            end
            OP_SH: begin
                if (b[0]) begin
                    misaligned = 1'b1;
                end else begin
                    byteenable = 4'(BE_HALF << b);
                    writedata  = {16'd0, data[15:0]} << sh_up;
                end
            end
            OP_SW: begin
                if (b != 2'd0) begin
                    misaligned = 1'b1;
                end else begin
                    byteenable = BE_WORD;
                    writedata  = data;
                end
            end
            OP_SWL: begin
                byteenable = BE_WORD >> (2'd3 - b);
                writedata  = data >> sh_swl;
            end
            OP_SWR: begin
                byteenable = 4'(BE_WORD << b);
                writedata  = data << sh_up;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_store_unit.sv
// MIPS store unit: narrows/aligns rt for SB/SH/SW/SWL/SWR and issues one
// word-aligned write with byte enables over a waitrequest bus.
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_op/req_addr/req_data : CPU store request
//   mem_write/mem_address/mem_writedata/mem_byteenable/mem_waitrequest :
//       data memory write port
//   done/addr_error/bus_error : one-cycle completion / error pulses
module mips_store_unit
    import mips_store_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    output logic        done,
    output logic        addr_error,
    output logic        bus_error
);

    localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic               req_ready_nxt, mem_write_nxt;
    logic               done_nxt, addr_error_nxt, bus_error_nxt;
    logic [31:0]        mem_address_nxt, mem_writedata_nxt;
    logic [3:0]         mem_byteenable_nxt;

    logic [3:0]         lane_be_c;
    logic [31:0]        lane_wd_c;
    logic               lane_bad_c;
    logic               wait_last_c;

    mips_store_lane u_lane (
        .op         (req_op),
        .b          (req_addr[1:0]),
        .data       (req_data),
        .byteenable (lane_be_c),
        .writedata  (lane_wd_c),
        .misaligned (lane_bad_c)
    );

    // Abort on the edge where waitrequest has been high for WAIT_LIMIT edges.
    assign wait_last_c = (WAIT_LIMIT != 32'd0) &&
                         ((32'(wait_cnt) + 32'd1) == WAIT_LIMIT);

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt          = state;
        wait_cnt_nxt       = '0;
        req_ready_nxt      = 1'b0;
        mem_write_nxt      = 1'b0;
        done_nxt           = 1'b0;
        addr_error_nxt     = 1'b0;
        bus_error_nxt      = 1'b0;
        mem_address_nxt    = mem_address;
        mem_writedata_nxt  = mem_writedata;
        mem_byteenable_nxt = mem_byteenable;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (lane_bad_c) begin
                        state_nxt      = ST_ERR;
                        addr_error_nxt = 1'b1;
                    end else begin
                        state_nxt          = ST_WRITE;
                        mem_write_nxt      = 1'b1;
                        mem_address_nxt    = {req_addr[31:2], 2'b00};
                        mem_writedata_nxt  = lane_wd_c;
                        mem_byteenable_nxt = lane_be_c;
                    end
                end else begin
                    req_ready_nxt = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!mem_waitrequest) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else if (wait_last_c) begin
                    state_nxt     = ST_IDLE;
                    bus_error_nxt = 1'b1;
                    req_ready_nxt = 1'b1;
                end else begin
                    mem_write_nxt = 1'b1;
                    wait_cnt_nxt  = wait_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt     = ST_IDLE;
                req_ready_nxt = 1'b1;
            end
            ST_ERR: begin
                state_nxt     = ST_IDLE;
                req_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt     = ST_IDLE;
                req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            req_ready      <= 1'b1;
            mem_write      <= 1'b0;
            mem_address    <= 32'd0;
            mem_writedata  <= 32'd0;
            mem_byteenable <= 4'd0;
            done           <= 1'b0;
            addr_error     <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_cnt_nxt;
            req_ready      <= req_ready_nxt;
            mem_write      <= mem_write_nxt;
            mem_address    <= mem_address_nxt;
            mem_writedata  <= mem_writedata_nxt;
            mem_byteenable <= mem_byteenable_nxt;
            done           <= done_nxt;
            addr_error     <= addr_error_nxt;
            bus_error      <= bus_error_nxt;
        end
    end

endmodule
